fetch_buffer: RTL

Instruction-fetch stage directly upstream of the instruction register and control unit in the multicycle RISC-V core. Owns the fetch PC and drives the 32-bit instruction memory read address. The memory has a 1-cycle synchronous read. Returned words are buffered in a small prefetch FIFO and presented to the consumer through a valid/ready handshake. Supports PC redirect for branches and jumps, with flush of buffered and in-flight words.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_buffer_if.sv | 37 +++
 rtl/fetch_fifo.sv | 50 +++++
 rtl/fetch_buffer.sv | 93 +++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'd0;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-stage bus: instruction memory read port, redirect input and consumer handshake.
// misalign_err exists only when FETCH_MISALIGN_TRAP_EN is defined.
interface fetch_buffer_if;
    import fetch_pkg::*;

    logic [31:0]        imem_raddress;
    logic [INSTR_W-1:0] imem_dataout;
    logic               redirect_valid;
    logic [XLEN-1:0]    redirect_pc;
    logic               instr_ready;
    logic               instr_valid;
    logic [INSTR_W-1:0] instr_data;
    logic [XLEN-1:0]    instr_pc;
    logic [XLEN-1:0]    fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic               misalign_err;

    modport master (
        output imem_raddress, instr_valid, instr_data, instr_pc, fetch_pc, misalign_err,
        input  imem_dataout, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_raddress, instr_valid, instr_data, instr_pc, fetch_pc, misalign_err,
        output imem_dataout, redirect_valid, redirect_pc, instr_ready
    );
`else
    modport master (
        output imem_raddress, instr_valid, instr_data, instr_pc, fetch_pc,
        input  imem_dataout, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_raddress, instr_valid, instr_data, instr_pc, fetch_pc,
        output imem_dataout, redirect_valid, redirect_pc, instr_ready
    );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of (pc, instr) entries with synchronous flush; head reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !do_pop)      count <= count + 1'b1;
            else if (!push && do_pop) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = head_valid ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: owns the fetch PC, issues 1-cycle synchronous reads, buffers returns.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets instead of aligning them.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned     DEPTH    = 2,
    parameter int unsigned     PC_STEP  = 4
) (
    input logic            clock,
    input logic            reset,
    fetch_buffer_if.master bus
);
    localparam int unsigned CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fpc;
    logic [XLEN-1:0] pc_q;
    logic            inflight;
    logic            pop;
    logic            push;
    logic            req_fire;
    logic            halted;
    logic [CW-1:0]   fifo_count;
    logic [31:0]     occupancy;
    logic [31:0]     capacity;
    fetch_entry_t    head;
    logic            head_valid;

    // The pop term lets a full-throughput stream keep one word buffered and one in flight.
    assign pop       = head_valid & bus.instr_ready;
    assign occupancy = 32'(fifo_count) + 32'(inflight);
    assign capacity  = DEPTH + 32'(pop);
    assign req_fire  = (occupancy < capacity) & ~bus.redirect_valid & ~halted;
    assign push      = inflight & ~bus.redirect_valid;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q;
    logic target_bad;

    assign target_bad = (bus.redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
            halted     <= 1'b0;
        end else if (bus.redirect_valid) begin
            halted <= target_bad;
            if (target_bad) misalign_q <= 1'b1;
        end
    end

    assign bus.misalign_err = misalign_q;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fpc      <= RESET_PC;
            pc_q     <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= req_fire;
            if (bus.redirect_valid) begin
                fpc <= word_align(bus.redirect_pc);
            end else if (req_fire) begin
                pc_q <= fpc;
                fpc  <= fpc + XLEN'(PC_STEP);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry ('{pc: pc_q, instr: bus.imem_dataout}),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .head       (head),
        .head_valid (head_valid),
        .count      (fifo_count)
    );

    assign bus.imem_raddress = fpc[31:0];
    assign bus.fetch_pc      = fpc;
    assign bus.instr_valid   = head_valid;
    assign bus.instr_data    = head.instr;
    assign bus.instr_pc      = head.pc;

endmodule
